// File: rtl/bp_clint_lite.sv
// Lite core-local interruptor: msip, mtimecmp and a prescaled 64-bit mtime
// behind a single-outstanding command/response port.
module bp_clint_lite #(
  parameter int timebase_div_p = 8,
  parameter int addr_width_p   = 40
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_w_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [1:0]              cmd_size_i,
  input  logic [63:0]             cmd_data_i,
  output logic                    resp_v_o,
  input  logic                    resp_yumi_i,
  output logic [63:0]             resp_data_o,
  output logic                    resp_err_o,
  output logic                    timer_irq_o,
  output logic                    software_irq_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam int PW = (timebase_div_p > 1) ? $clog2(timebase_div_p) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(timebase_div_p - 1);

  logic [0:0]    state_q;
  logic [PW-1:0] ps_q;
  logic [63:0]   mtime_q, mtimecmp_q;
  logic          msip_q;
  logic [63:0]   resp_data_q;
  logic          resp_err_q;
  logic          timer_irq_q;

  logic [19:0] off;
  logic        sz4, sz8, misalign, hit_msip, hit_cmp, hit_time, err;
  logic        accept, wr_ok, wrap;
  logic [63:0] rd_val, rd_sel, wr_time, wr_cmp;

  // Upper address bits are don't-care by design.
  logic unused_addr;
  assign unused_addr = ^cmd_addr_i[addr_width_p-1:20];

  assign cmd_ready_o    = (state_q == IDLE) & ~reset_i;
  assign resp_v_o       = (state_q == RESP) & ~reset_i;
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign timer_irq_o    = timer_irq_q;
  assign software_irq_o = msip_q;

  assign accept = cmd_v_i & cmd_ready_o;
  assign wrap   = (ps_q == PS_MAX);

  always_comb begin
    off      = cmd_addr_i[19:0];
    sz4      = (cmd_size_i == 2'd2);
    sz8      = (cmd_size_i == 2'd3);
    misalign = sz8 ? (|off[2:0]) : (|off[1:0]);
    hit_msip = sz4 & (off == 20'h0_0000);
    hit_cmp  = (off[19:3] == 17'h0_0800);
    hit_time = (off[19:3] == 17'h0_17ff);
    err      = ~(sz4 | sz8) | misalign | ~(hit_msip | hit_cmp | hit_time);
    wr_ok    = accept & cmd_w_i & ~err;
  end

  // Reads see pre-update state; 4B accesses pick a half by addr[2].
  always_comb begin
    rd_val = hit_msip ? {63'h0, msip_q} : (hit_cmp ? mtimecmp_q : mtime_q);
    rd_sel = sz8 ? rd_val
                 : {32'h0, (off[2] ? rd_val[63:32] : rd_val[31:0])};
    if (sz8) begin
      wr_time = cmd_data_i;
      wr_cmp  = cmd_data_i;
    end else if (off[2]) begin
      wr_time = {cmd_data_i[31:0], mtime_q[31:0]};
      wr_cmp  = {cmd_data_i[31:0], mtimecmp_q[31:0]};
    end else begin
      wr_time = {mtime_q[63:32], cmd_data_i[31:0]};
      wr_cmp  = {mtimecmp_q[63:32], cmd_data_i[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ps_q        <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      ps_q <= wrap ? '0 : ps_q + 1'b1;
      // A software write wins over the tick; the prescaler keeps running.
      if (wr_ok & hit_time)   mtime_q <= wr_time;
      else if (wrap)          mtime_q <= mtime_q + 64'd1;
      if (wr_ok & hit_cmp)    mtimecmp_q <= wr_cmp;
      if (wr_ok & hit_msip)   msip_q <= cmd_data_i[0];
      // Compare of the registered values, so the irq lags mtime by one cycle.
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      if (accept) begin
        state_q     <= RESP;
        resp_err_q  <= err;
        resp_data_q <= (err | cmd_w_i) ? 64'h0 : rd_sel;
      end else if ((state_q == RESP) & resp_yumi_i) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bp_clint_lite.sv
// Bench for bp_clint_lite: vector table plus hand sequences for timing corners,
// with a response scoreboard queue.
module tb_bp_clint_lite;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0, cmd_w_i = 1'b0, resp_yumi_i = 1'b0;
  logic [39:0] cmd_addr_i = '0;
  logic [1:0]  cmd_size_i = '0;
  logic [63:0] cmd_data_i = '0;
  logic        cmd_ready_o, resp_v_o, resp_err_o, timer_irq_o, software_irq_o;
  logic [63:0] resp_data_o;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } resp_t;
  resp_t sb[$];

  typedef struct {
    logic        w;
    logic [39:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] exp;
    logic        err;
    logic        use_mtime;
  } vec_t;
  localparam int NV = 18;
  vec_t vt[NV];

  bp_clint_lite #(.timebase_div_p(8), .addr_width_p(40)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_w_i(cmd_w_i),
    .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_data_i(cmd_data_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .timer_irq_o(timer_irq_o), .software_irq_o(software_irq_o)
  );

  always #5 clk = ~clk;

  // Non-reset edges since reset release; mtime should be cyc/8 absent writes.
  always @(posedge clk) begin
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Issue one command, check the response one cycle later, optionally hold
  // off yumi for a few cycles, then consume.
  task automatic do_cmd(input logic w, input logic [39:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input logic [63:0] ed, input logic ee,
                        input int hold, input string nm);
    resp_t r;
    chk({nm, " ready"}, {63'h0, cmd_ready_o}, 64'h1);
    cmd_v_i = 1'b1; cmd_w_i = w; cmd_addr_i = a; cmd_size_i = sz; cmd_data_i = d;
    sb.push_back('{ed, ee});
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
    @(negedge clk);
    chk({nm, " resp_v"}, {63'h0, resp_v_o}, 64'h1);
    if (resp_v_o && sb.size() > 0) begin
      r = sb.pop_front();
      chk({nm, " data"}, resp_data_o, r.data);
      chk({nm, " err"}, {63'h0, resp_err_o}, {63'h0, r.err});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, " hold ready"}, {63'h0, cmd_ready_o}, 64'h0);
        chk({nm, " hold resp_v"}, {63'h0, resp_v_o}, 64'h1);
        chk({nm, " hold data"}, resp_data_o, r.data);
        chk({nm, " hold err"}, {63'h0, resp_err_o}, {63'h0, r.err});
      end
      resp_yumi_i = 1'b1;
      @(posedge clk); #1;
      resp_yumi_i = 1'b0;
      if (hold > 0) chk({nm, " ready after yumi"}, {63'h0, cmd_ready_o}, 64'h1);
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [63:0] e;
    int lo;
    vt[0]  = '{1'b1, 40'h0_4000, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 40'h0_4000, 2'd3, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 40'h0_4004, 2'd2, 64'h0, 64'h0000_0000_1234_5678, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 40'h0_4000, 2'd2, 64'h0, 64'h0000_0000_9ABC_DEF0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 40'h0_4004, 2'd2, 64'hFFFF_FFFF_0000_0001, 64'h0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 40'h0_4000, 2'd3, 64'h0, 64'h0000_0001_9ABC_DEF0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 40'h0_4004, 2'd3, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 40'h0_4000, 2'd1, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 40'h0_4000, 2'd3, 64'h0, 64'h0000_0001_9ABC_DEF0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 40'h0_0000, 2'd3, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 40'h0_0008, 2'd2, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 40'h0_0002, 2'd2, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 40'h0_bff8, 2'd3, 64'h0, 64'h0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 40'h0_bff8, 2'd2, 64'h0, 64'h0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 40'h0_4000, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 40'h0_bff8, 2'd0, 64'h0, 64'h0, 1'b1, 1'b0};
    vt[16] = '{1'b0, 40'hAB_0000_4000, 2'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vt[17] = '{1'b0, 40'h0_1_4000, 2'd3, 64'h0, 64'h0, 1'b1, 1'b0};

    // Reset: handshake outputs gated, irqs low.
    repeat (3) begin
      @(negedge clk);
      chk("rst ready", {63'h0, cmd_ready_o}, 64'h0);
      chk("rst resp_v", {63'h0, resp_v_o}, 64'h0);
    end
    chk("rst timer_irq", {63'h0, timer_irq_o}, 64'h0);
    chk("rst sw_irq", {63'h0, software_irq_o}, 64'h0);
    @(posedge clk); #1;
    reset_i = 1'b0;

    // 16 idle cycles -> mtime = 2.
    repeat (16) @(posedge clk);
    #1;
    chk("idle timer_irq", {63'h0, timer_irq_o}, 64'h0);
    chk("idle sw_irq", {63'h0, software_irq_o}, 64'h0);
    do_cmd(1'b0, 40'h0_bff8, 2'd3, 64'h0, 64'd2, 1'b0, 0, "mtime16");

    // msip set, read back, clear.
    do_cmd(1'b1, 40'h0_0000, 2'd2, 64'h1, 64'h0, 1'b0, 0, "msip wr1");
    chk("msip sw_irq", {63'h0, software_irq_o}, 64'h1);
    do_cmd(1'b0, 40'h0_0000, 2'd2, 64'h0, 64'h1, 1'b0, 0, "msip rd");
    do_cmd(1'b1, 40'h0_0000, 2'd2, 64'h0, 64'h0, 1'b0, 0, "msip wr0");
    chk("msip clr sw_irq", {63'h0, software_irq_o}, 64'h0);

    for (int i = 0; i < NV; i++) begin
      e = vt[i].use_mtime ? 64'(cyc / 8) : vt[i].exp;
      do_cmd(vt[i].w, vt[i].addr, vt[i].size, vt[i].data, e, vt[i].err, 0,
             $sformatf("vec%0d", i));
    end

    // Back-pressure: response held for 5 cycles.
    do_cmd(1'b0, 40'h0_4000, 2'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5, "hold");

    // Reset while a response is pending discards it.
    cmd_v_i = 1'b1; cmd_w_i = 1'b1; cmd_addr_i = 40'h0; cmd_size_i = 2'd2; cmd_data_i = 64'h1;
    @(posedge clk); #1;
    cmd_v_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    chk("rstresp resp_v", {63'h0, resp_v_o}, 64'h0);
    chk("rstresp ready", {63'h0, cmd_ready_o}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("rstresp post resp_v", {63'h0, resp_v_o}, 64'h0);
    chk("rstresp post ready", {63'h0, cmd_ready_o}, 64'h1);
    chk("rstresp post sw_irq", {63'h0, software_irq_o}, 64'h0);

    // mtimecmp = 5: mtime hits 5 after 40 edges, irq follows one edge later.
    do_cmd(1'b1, 40'h0_4000, 2'd3, 64'd5, 64'h0, 1'b0, 0, "cmp5");
    for (int i = 0; i < 60 && cyc < 44; i++) begin
      @(negedge clk);
      chk($sformatf("timer_irq cyc%0d", cyc), {63'h0, timer_irq_o},
          (cyc >= 41) ? 64'h1 : 64'h0);
    end

    // mtime high-half write landing on a prescaler wrap: no increment.
    @(posedge clk); #1;
    for (int i = 0; i < 16 && (cyc % 8) != 7; i++) begin
      @(posedge clk); #1;
    end
    lo = cyc / 8;
    do_cmd(1'b1, 40'h0_bffc, 2'd2, 64'hDEAD_BEEF, 64'h0, 1'b0, 0, "mtime hi wr");
    do_cmd(1'b0, 40'h0_bff8, 3'd3, 64'h0, {32'hDEAD_BEEF, 32'(lo)}, 1'b0, 0, "mtime hi rd");
    do_cmd(1'b0, 40'h0_bffc, 2'd2, 64'h0, 64'hDEAD_BEEF, 1'b0, 0, "mtime hi rd4");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bp_clint_lite.md
BP_CLINT_LITE -- requirements
Module: bp_clint_lite

Interface
REQ-001 The block SHALL have parameter timebase_div_p, default 8, meaning core-clock cycles per mtime increment (legal range 1..256).
REQ-002 The block SHALL have parameter addr_width_p, default 40, meaning command address width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port cmd_v_i, input, 1, command valid.
REQ-006 The block SHALL have port cmd_ready_o, output, 1, command accepted when cmd_v_i & cmd_ready_o.
REQ-007 The block SHALL have port cmd_w_i, input, 1, 1 = write, 0 = read.
REQ-008 The block SHALL have port cmd_addr_i, input, addr_width_p, byte address; only bits [19:0] are decoded.
REQ-009 The block SHALL have port cmd_size_i, input, 2, access size: 2 = 4B, 3 = 8B; 0 and 1 are unsupported.
REQ-010 The block SHALL have port cmd_data_i, input, 64, write data; for 4B writes only bits [31:0] are used.
REQ-011 The block SHALL have port resp_v_o, output, 1, response valid.
REQ-012 The block SHALL have port resp_yumi_i, input, 1, response consumed; legal only while resp_v_o = 1.
REQ-013 The block SHALL have port resp_data_o, output, 64, read data; zero for writes.
REQ-014 The block SHALL have port resp_err_o, output, 1, flags an unsupported size, a misaligned access, or an unmapped offset.
REQ-015 The block SHALL have port timer_irq_o, output, 1, machine timer interrupt.
REQ-016 The block SHALL have port software_irq_o, output, 1, machine software interrupt.

Function
REQ-017 The block SHALL implement three registers at offsets addr[19:0]: msip at 0x0_0000 (bit 0 only), mtimecmp at 0x0_4000 (64b), mtime at 0x0_bff8 (64b).
REQ-018 The block SHALL implement a two-state FSM: IDLE (cmd_ready_o = 1, resp_v_o = 0) and RESP (cmd_ready_o = 0, resp_v_o = 1); IDLE -> RESP on accept; RESP -> IDLE on resp_yumi_i; one command outstanding.
REQ-019 The block SHALL make the response visible exactly 1 cycle after accept, and SHALL hold resp_data_o and resp_err_o stable while in RESP.
REQ-020 For 8B accesses, addr[2:0] SHALL be 0; otherwise resp_err_o = 1, the write is dropped, and read data is 0.
REQ-021 For 4B accesses, addr[1:0] SHALL be 0; addr[2] = 0 selects bits [31:0] and addr[2] = 1 selects bits [63:32]; read data is zero-extended into resp_data_o[31:0]; writes update only the selected half.
REQ-022 msip SHALL accept 4B accesses only at offset 0x0_0000; an 8B access to msip, an unmapped offset, or size 0/1 SHALL give resp_err_o = 1, no state change, and read data 0.
REQ-023 All register writes SHALL take effect on the accept edge, so a subsequent read observes them.
REQ-024 A prescaler SHALL count 0..timebase_div_p-1 and wrap; mtime SHALL increment by 1 on the wrap cycle; mtime wraps 2^64-1 -> 0.
REQ-025 A write to mtime SHALL override an increment in the same cycle, and the prescaler SHALL continue unaffected.
REQ-026 A read of mtime SHALL return the value before the accept-edge update.
REQ-027 timer_irq_o SHALL be registered as (mtime >= mtimecmp), unsigned and evaluated on post-update values, so it asserts 1 cycle after the condition holds.
REQ-028 software_irq_o SHALL equal msip bit 0 directly from the register.

Reset
REQ-029 While reset_i = 1 at a clock edge, the block SHALL reset: FSM -> IDLE, mtime = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, resp_data_o = 0, resp_err_o = 0, timer_irq_o = 0, software_irq_o = 0.
REQ-030 During reset cycles, cmd_ready_o = 0 and resp_v_o = 0.
REQ-031 Reset asserted in RESP SHALL discard the pending response with no further effect.

Verification
REQ-032 The bench SHALL cover: release reset with no commands for 16 cycles -> mtime = 2, timer_irq_o = 0, software_irq_o = 0.
REQ-033 The bench SHALL cover: 8B write mtimecmp = 5 at 0x4000, then idle -> timer_irq_o rises 1 cycle after mtime reaches 5.
REQ-034 The bench SHALL cover: 4B write 0x1 to 0x0000, then 4B read 0x0000 -> software_irq_o = 1 the cycle after accept, and resp_data_o = 0x1.
REQ-035 The bench SHALL cover: 4B write 0xDEAD_BEEF at 0xBFFC coinciding with a prescaler wrap -> mtime[63:32] = 0xDEAD_BEEF, mtime[31:0] unchanged (no increment that cycle).
REQ-036 The bench SHALL cover: 8B read at 0x4004, and a size 1 write -> resp_err_o = 1, resp_data_o = 0, no register change.
REQ-037 The bench SHALL cover: hold resp_yumi_i = 0 for 5 cycles -> cmd_ready_o = 0 and response stable throughout; then yumi -> cmd_ready_o = 1 the next cycle.
